// File: rtl/link_freq_meter.sv
// Link carrier period meter: measures edge-to-edge distance in clk cycles, qualifies lock and
// converts the period to Hz with a serial divider. Define LINK_FREQ_AVG_EN to divide by a 4-period mean.
`timescale 1ns/1ps
module link_freq_meter #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned MIN_PERIOD = 1000,
    parameter int unsigned MAX_PERIOD = 10000,
    parameter int unsigned TOL        = 16,
    parameter int unsigned LOCK_CNT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link,
    output logic [31:0] period,
    output logic [31:0] f_meas,
    output logic        f_valid,
    output logic        freq_rdy,
    output logic        link_alive
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);

    if (MIN_PERIOD < 40) begin : g_min_period_check
        $error("MIN_PERIOD must be at least 40 so consecutive divides never overlap");
    end

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   period_q, period_d;
    logic [31:0]   f_meas_q, f_meas_d;
    logic          f_valid_q, f_valid_d;
    logic          freq_rdy_q, freq_rdy_d;
    logic          link_alive_q, link_alive_d;
    logic [GW-1:0] good_q, good_d;
    logic          div_busy_q, div_busy_d;
    logic [5:0]    div_cnt_q, div_cnt_d;
    logic [31:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;

    logic          rise, glitch, accept, rdy_set;
    logic [31:0]   m, diff, divisor;
    logic [32:0]   rem_shift, rem_sub;
`ifdef LINK_FREQ_AVG_EN
    logic [31:0]   slot_q [4];
    logic [31:0]   slot_d [4];
    logic [33:0]   sum;
`endif

    always_comb begin
        rise    = sync2_q & ~sync3_q;
        m       = cnt_q;
        glitch  = (m < MIN_PERIOD);
        diff    = (m >= period_q) ? (m - period_q) : (period_q - m);
        accept  = rise && !glitch && (state_q != IDLE);

        sync1_d = link;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        if (rise)
            cnt_d = 32'd1;
        else if (cnt_q >= MAX_PERIOD)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 32'd1;

`ifdef LINK_FREQ_AVG_EN
        // Entry into MEAS seeds every slot with the reference so the first mean is exact.
        for (int i = 0; i < 4; i++) slot_d[i] = slot_q[i];
        if (accept && state_q == ARM) begin
            for (int i = 0; i < 4; i++) slot_d[i] = m;
        end else if (accept) begin
            slot_d[0] = slot_q[1];
            slot_d[1] = slot_q[2];
            slot_d[2] = slot_q[3];
            slot_d[3] = m;
        end
        sum     = 34'(slot_d[0]) + 34'(slot_d[1]) + 34'(slot_d[2]) + 34'(slot_d[3]);
        divisor = sum[33:2];
`else
        divisor = m;
`endif

        div_busy_d = div_busy_q;
        div_cnt_d  = div_cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        f_meas_d   = f_meas_q;
        f_valid_d  = 1'b0;
        rdy_set    = 1'b0;
        rem_shift  = {rem_q, quo_q[31]};
        rem_sub    = rem_shift - {1'b0, dvs_q};
        if (accept) begin
            div_busy_d = 1'b1;
            div_cnt_d  = 6'd0;
            rem_d      = 32'd0;
            quo_d      = 32'(CLK_HZ);
            dvs_d      = divisor;
        end else if (div_busy_q) begin
            if (div_cnt_q == 6'd32) begin
                div_busy_d = 1'b0;
                f_meas_d   = quo_q;
                f_valid_d  = 1'b1;
                rdy_set    = (good_q == LOCK_V);
            end else begin
                // Partial remainder is always below the divisor, so bit 32 of the difference is the borrow.
                if (!rem_sub[32]) begin
                    rem_d = rem_sub[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                div_cnt_d = div_cnt_q + 6'd1;
            end
        end

        state_d      = state_q;
        period_d     = period_q;
        good_d       = good_q;
        link_alive_d = link_alive_q;
        freq_rdy_d   = freq_rdy_q | rdy_set;
        if (rise) begin
            case (state_q)
                IDLE: begin
                    state_d      = ARM;
                    link_alive_d = 1'b1;
                end
                ARM: if (!glitch) begin
                    state_d  = MEAS;
                    period_d = m;
                    good_d   = '0;
                end
                MEAS: begin
                    if (glitch || diff > TOL) begin
                        good_d     = '0;
                        freq_rdy_d = 1'b0;
                    end else if (good_q != LOCK_V) begin
                        good_d = good_q + 1'b1;
                    end
                    if (!glitch) period_d = m;
                end
                default: state_d = IDLE;
            endcase
        end else if (cnt_q >= MAX_PERIOD) begin
            state_d      = IDLE;
            link_alive_d = 1'b0;
            freq_rdy_d   = 1'b0;
            good_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            cnt_q        <= 32'd0;
            period_q     <= 32'd0;
            f_meas_q     <= 32'd0;
            f_valid_q    <= 1'b0;
            freq_rdy_q   <= 1'b0;
            link_alive_q <= 1'b0;
            good_q       <= '0;
            div_busy_q   <= 1'b0;
            div_cnt_q    <= 6'd0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            dvs_q        <= 32'd0;
`ifdef LINK_FREQ_AVG_EN
            for (int i = 0; i < 4; i++) slot_q[i] <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            f_meas_q     <= f_meas_d;
            f_valid_q    <= f_valid_d;
            freq_rdy_q   <= freq_rdy_d;
            link_alive_q <= link_alive_d;
            good_q       <= good_d;
            div_busy_q   <= div_busy_d;
            div_cnt_q    <= div_cnt_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
`ifdef LINK_FREQ_AVG_EN
            for (int i = 0; i < 4; i++) slot_q[i] <= slot_d[i];
`endif
        end
    end

    assign period     = period_q;
    assign f_meas     = f_meas_q;
    assign f_valid    = f_valid_q;
    assign freq_rdy   = freq_rdy_q;
    assign link_alive = link_alive_q;

endmodule
